// File: rtl/eq_band_mixer.sv
// eq_band_mixer: mixes the three equalizer bands into one output sample.
// Per sample it captures three band samples and three gains, then multiplies
// and accumulates each band in turn on one shared multiplier. The sum is
// saturated to the Q(p.f) sample format and flagged by a one-cycle valid pulse.
// Optional build macro MIXER_ROUND_EN: round each product half toward
// +infinity before it is scaled back. When the macro is undefined, each product
// is truncated toward -infinity (floor).
module eq_band_mixer #(
    parameter int p     = 13,
    parameter int f     = 18,
    parameter int Width = p + f + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic signed [Width-1:0] yk0,
    input  logic signed [Width-1:0] yk1,
    input  logic signed [Width-1:0] yk2,
    input  logic signed [Width-1:0] g0,
    input  logic signed [Width-1:0] g1,
    input  logic signed [Width-1:0] g2,
    output logic signed [Width-1:0] yk,
    output logic                    valid,
    output logic                    busy,
    output logic                    overrun
);

    // Full product, scaled product, and accumulator widths.
    localparam int PW = 2 * Width;
    localparam int SW = 2 * Width - f;
    localparam int AW = SW + 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC0 = 2'd1,
        MAC1 = 2'd2,
        MAC2 = 2'd3
    } state_t;

    state_t                  state_r;
    logic signed [Width-1:0] ykc0_r, ykc1_r, ykc2_r;
    logic signed [Width-1:0] gc0_r, gc1_r, gc2_r;
    logic signed [AW-1:0]    acc_r;

    logic signed [Width-1:0] mul_a_s, mul_b_s;
    logic signed [PW-1:0]    prod_full_s;
    logic signed [PW-1:0]    prod_adj_s;
    logic signed [SW-1:0]    prod_s;
    logic signed [AW-1:0]    prod_ext_s;
    logic signed [AW-1:0]    sum_s;

`ifdef MIXER_ROUND_EN
    // Half an output LSB in the full-product scale.
    localparam logic signed [PW-1:0] round_bias =
        {{(PW - f){1'b0}}, 1'b1, {(f - 1){1'b0}}};
`endif

    // Clamp the wide accumulator sum into the signed sample range.
    function automatic logic [Width-1:0] sat_fn(input logic [AW-1:0] v);
        logic [AW-Width:0] top;
        top = v[AW-1:Width-1];
        if ((&top) || !(|top)) begin
            sat_fn = v[Width-1:0];
        end else if (v[AW-1]) begin
            sat_fn = {1'b1, {(Width - 1){1'b0}}};
        end else begin
            sat_fn = {1'b0, {(Width - 1){1'b1}}};
        end
    endfunction

    // Route the captured band and gain for the current MAC step to the multiplier.
    always_comb begin
        mul_a_s = {Width{1'b0}};
        mul_b_s = {Width{1'b0}};
        case (state_r)
            MAC0: begin
                mul_a_s = ykc0_r;
                mul_b_s = gc0_r;
            end
            MAC1: begin
                mul_a_s = ykc1_r;
                mul_b_s = gc1_r;
            end
            MAC2: begin
                mul_a_s = ykc2_r;
                mul_b_s = gc2_r;
            end
            default: begin
                mul_a_s = {Width{1'b0}};
                mul_b_s = {Width{1'b0}};
            end
        endcase
    end

    // Shared multiplier: sign-extend the product, scale it back by f, and add it to the running sum.
    always_comb begin
        prod_full_s = PW'(mul_a_s) * PW'(mul_b_s);
`ifdef MIXER_ROUND_EN
        prod_adj_s  = prod_full_s + round_bias;
`else
        prod_adj_s  = prod_full_s;
`endif
        prod_s      = SW'(prod_adj_s >>> f);
        prod_ext_s  = {{2{prod_s[SW-1]}}, prod_s};
        sum_s       = acc_r + prod_ext_s;
    end

    // Mix sequencer: capture, three MAC steps, saturate and publish.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            ykc0_r  <= {Width{1'b0}};
            ykc1_r  <= {Width{1'b0}};
            ykc2_r  <= {Width{1'b0}};
            gc0_r   <= {Width{1'b0}};
            gc1_r   <= {Width{1'b0}};
            gc2_r   <= {Width{1'b0}};
            acc_r   <= {AW{1'b0}};
            yk      <= {Width{1'b0}};
            valid   <= 1'b0;
            busy    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            valid <= 1'b0;
            // A strobe that arrives while a mix is running is dropped but remembered.
            if (enable && (state_r != IDLE)) begin
                overrun <= 1'b1;
            end else begin
                overrun <= overrun;
            end
            case (state_r)
                IDLE: begin
                    if (enable) begin
                        ykc0_r  <= yk0;
                        ykc1_r  <= yk1;
                        ykc2_r  <= yk2;
                        gc0_r   <= g0;
                        gc1_r   <= g1;
                        gc2_r   <= g2;
                        acc_r   <= {AW{1'b0}};
                        busy    <= 1'b1;
                        state_r <= MAC0;
                    end else begin
                        busy    <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                MAC0: begin
                    acc_r   <= prod_ext_s;
                    busy    <= 1'b1;
                    state_r <= MAC1;
                end
                MAC1: begin
                    acc_r   <= sum_s;
                    busy    <= 1'b1;
                    state_r <= MAC2;
                end
                MAC2: begin
                    yk      <= sat_fn(sum_s);
                    valid   <= 1'b1;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eq_band_mixer.sv
// Self-checking bench for eq_band_mixer. Each accepted mix pushes its
// expected result and due cycle to a scoreboard. The result comes from an
// independent 64-bit reference model. A negedge monitor pops and compares
// entries on every valid pulse.
module tb_eq_band_mixer;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [31:0] yk0, yk1, yk2, g0, g1, g2;
    logic [31:0] yk;
    logic        valid, busy, overrun;

    typedef struct {
        int          due;
        logic [31:0] val;
    } exp_t;

    exp_t        sb_q[$];
    int          cyc;
    int          free_cyc;
    int          n_cmp;
    int          n_err;
    int          n_start;

    eq_band_mixer dut (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .yk0     (yk0),
        .yk1     (yk1),
        .yk2     (yk2),
        .g0      (g0),
        .g1      (g1),
        .g2      (g2),
        .yk      (yk),
        .valid   (valid),
        .busy    (busy),
        .overrun (overrun)
    );

    // 10 ns system clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter; during the cycle that follows posedge number k, cyc == k.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Reference model: a 64-bit multiply-accumulate followed by a clamp.
    function automatic logic [31:0] model_mix(input logic [31:0] a0, input logic [31:0] a1,
                                              input logic [31:0] a2, input logic [31:0] b0,
                                              input logic [31:0] b1, input logic [31:0] b2);
        longint acc;
        longint pr;
        logic [31:0] a [3];
        logic [31:0] b [3];
        a[0] = a0; a[1] = a1; a[2] = a2;
        b[0] = b0; b[1] = b1; b[2] = b2;
        acc = 64'sd0;
        for (int i = 0; i < 3; i++) begin
            pr = longint'($signed(a[i])) * longint'($signed(b[i]));
`ifdef MIXER_ROUND_EN
            pr = pr + 64'sd131072;
`endif
            acc = acc + (pr >>> 18);
        end
        if (acc > 64'sd2147483647) return 32'h7FFF_FFFF;
        if (acc < -64'sd2147483648) return 32'h8000_0000;
        return acc[31:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Idle cycles with scrambled inputs, so that captured values are the only ones that matter.
    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            yk0 = $urandom; yk1 = $urandom; yk2 = $urandom;
            g0  = $urandom; g1  = $urandom; g2  = $urandom;
            tick();
        end
    endtask

    // Pulse enable for one cycle; the pulse queues an expectation when the model says the mixer is idle.
    task automatic start_mix(input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2,
                             input logic [31:0] b0, input logic [31:0] b1, input logic [31:0] b2);
        exp_t e;
        yk0 = a0; yk1 = a1; yk2 = a2;
        g0  = b0; g1  = b1; g2  = b2;
        enable = 1'b1;
        if (cyc >= free_cyc) begin
            e.due = cyc + 4;
            e.val = model_mix(a0, a1, a2, b0, b1, b2);
            sb_q.push_back(e);
            free_cyc = cyc + 4;
            n_start++;
        end
        tick();
        enable = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        sb_q.delete();
        free_cyc = cyc + 1;
        repeat (n) tick();
        rst = 1'b0;
    endtask

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (sb_q.size() > 0 && cyc > sb_q[0].due) begin
                check_value("missing_valid", 32'(valid), 32'd1);
                void'(sb_q.pop_front());
            end
            if (valid === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check_value("spurious_valid", 32'(valid), 32'd0);
                end else begin
                    check_value("valid_cycle", 32'(cyc), 32'(sb_q[0].due));
                    check_value("yk_result", yk, sb_q[0].val);
                    void'(sb_q.pop_front());
                end
            end
        end
    end

    // Safety net against a hung run.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [31:0] hold;
        n_cmp = 0; n_err = 0; n_start = 0;
        cyc = 0; free_cyc = 0;
        rst = 1'b1; enable = 1'b0;
        yk0 = 32'd0; yk1 = 32'd0; yk2 = 32'd0;
        g0 = 32'd0; g1 = 32'd0; g2 = 32'd0;

        // Reset, then a quiet idle stretch.
        do_reset(3);
        for (int i = 0; i < 10; i++) begin
            check_value("idle_yk", yk, 32'd0);
            check_value("idle_valid", 32'(valid), 32'd0);
            check_value("idle_busy", 32'(busy), 32'd0);
            check_value("idle_overrun", 32'(overrun), 32'd0);
            tick();
        end

        // Nominal mix with cycle-exact handshake checks.
        start_mix(32'sd262144, 32'sd524288, -32'sd131072, 32'sd262144, 32'sd131072, 32'sd524288);
        check_value("nom_busy1", 32'(busy), 32'd1);
        check_value("nom_valid1", 32'(valid), 32'd0);
        idle_cycles(1);
        check_value("nom_busy2", 32'(busy), 32'd1);
        idle_cycles(1);
        check_value("nom_busy3", 32'(busy), 32'd1);
        check_value("nom_valid3", 32'(valid), 32'd0);
        idle_cycles(1);
        check_value("nom_valid4", 32'(valid), 32'd1);
        check_value("nom_busy4", 32'(busy), 32'd0);
        check_value("nom_yk", yk, 32'd262144);
        idle_cycles(1);
        check_value("nom_valid5", 32'(valid), 32'd0);
        check_value("nom_hold", yk, 32'd262144);

        // Positive and negative saturation.
        start_mix(32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 32'd524288, 32'd524288, 32'd524288);
        idle_cycles(3);
        check_value("sat_pos", yk, 32'h7FFF_FFFF);
        idle_cycles(1);
        start_mix(32'hC000_0000, 32'hC000_0000, 32'hC000_0000, 32'd524288, 32'd524288, 32'd524288);
        idle_cycles(3);
        check_value("sat_neg", yk, 32'h8000_0000);
        idle_cycles(1);

        // Sub-LSB products: floor versus round-half-up.
        start_mix(32'hFFFF_FFFF, 32'd0, 32'd0, 32'd131072, 32'd0, 32'd0);
        idle_cycles(3);
`ifdef MIXER_ROUND_EN
        check_value("round_neg", yk, 32'd0);
`else
        check_value("round_neg", yk, 32'hFFFF_FFFF);
`endif
        idle_cycles(1);
        start_mix(32'd1, 32'd0, 32'd0, 32'd131072, 32'd0, 32'd0);
        idle_cycles(3);
`ifdef MIXER_ROUND_EN
        check_value("round_pos", yk, 32'd1);
`else
        check_value("round_pos", yk, 32'd0);
`endif
        idle_cycles(1);

        // Overrun: a second strobe while busy is dropped and sets the sticky flag.
        do_reset(3);
        start_mix(32'sd262144, 32'sd262144, 32'sd262144, 32'sd262144, 32'sd262144, 32'sd262144);
        idle_cycles(1);
        check_value("ovr_before", 32'(overrun), 32'd0);
        start_mix(32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 32'd524288, 32'd524288, 32'd524288);
        check_value("ovr_set", 32'(overrun), 32'd1);
        idle_cycles(8);
        check_value("ovr_sticky", 32'(overrun), 32'd1);

        // Back-to-back: enable exactly four cycles apart is accepted.
        do_reset(3);
        start_mix(32'sd524288, 32'sd0, 32'sd0, 32'sd262144, 32'sd0, 32'sd0);
        idle_cycles(3);
        start_mix(32'sd0, 32'sd0, 32'sd262144, 32'sd0, 32'sd0, -32'sd262144);
        idle_cycles(4);
        check_value("b2b_overrun", 32'(overrun), 32'd0);
        check_value("b2b_yk", yk, 32'hFFFC_0000);

        // Reset in the middle of a mix aborts it; an immediate restart is clean.
        start_mix(32'sd262144, 32'sd262144, 32'sd262144, 32'sd262144, 32'sd262144, 32'sd262144);
        idle_cycles(1);
        do_reset(1);
        check_value("rstmid_busy", 32'(busy), 32'd0);
        check_value("rstmid_yk", yk, 32'd0);
        check_value("rstmid_valid", 32'(valid), 32'd0);
        start_mix(32'sd131072, 32'sd131072, 32'sd0, 32'sd524288, 32'sd262144, 32'sd0);
        idle_cycles(3);
        check_value("rstmid_valid4", 32'(valid), 32'd1);
        check_value("rstmid_yk4", yk, 32'd393216);
        idle_cycles(1);

        // Random mixes with moderate magnitudes and varying gaps.
        for (int i = 0; i < 24; i++) begin
            logic [31:0] r [6];
            for (int j = 0; j < 6; j++) begin
                hold = $urandom;
                r[j] = (i % 4 == 3) ? hold : {{12{hold[20]}}, hold[19:0]};
            end
            start_mix(r[0], r[1], r[2], r[3], r[4], r[5]);
            idle_cycles(3 + (i % 3));
        end

        // Drain: every queued expectation must have been consumed.
        n = 0;
        while (sb_q.size() > 0 && n < 20) begin
            tick();
            n++;
        end
        check_value("drain", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
